blink_scheduler: RTL and testbench

Shares one status LED between up to NREQ requesters, each asking for a blink code: N pulses followed by a dark gap. Round-robin arbitration picks a requester, the code plays to completion, then the next requester is served. The time base is derived from the board clock frequency. The block sits between status sources (PLL lock, error flags, boot stages) and the board LED pin.

---
 rtl/blink_scheduler_pkg.sv | 24 ++
 rtl/blink_scheduler_unit_tick.sv | 34 +++
 rtl/blink_scheduler.sv | 172 +++++++++++++++++
 tb/tb_blink_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_scheduler_pkg.sv
// Shared definitions for blink_scheduler: default time base, FSM states and
// the divider helper that converts clock frequency and unit length into cycles.
package blink_scheduler_pkg;

    localparam int unsigned DEFAULT_FREQ      = 50_000_000;
    localparam int unsigned DEFAULT_UNIT_MS   = 100;
    localparam int unsigned DEFAULT_GAP_UNITS = 3;
    localparam int unsigned HB_RATIO          = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // 64-bit product so large board clocks times long units cannot overflow
    function automatic int unsigned calc_div(input int unsigned freq, input int unsigned unit_ms);
        longint unsigned prod;
        prod = 64'(freq) * 64'(unit_ms);
        return 32'(prod / 64'd1000);
    endfunction

endpackage

// File: rtl/blink_scheduler_unit_tick.sv
// DIV-cycle prescaler: emits a one-cycle tick at the end of every unit and
// restarts from zero whenever restart_i is high.
module blink_scheduler_unit_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned PW = $clog2(DIV);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == PW'(DIV - 1));

    always_comb begin
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blink_scheduler.sv
// Round-robin sharing of one status LED among NREQ blink-code requesters.
// Optional idle heartbeat: define BLINK_SCHED_HEARTBEAT_EN.
module blink_scheduler
    import blink_scheduler_pkg::*;
#(
    parameter int unsigned FREQ      = DEFAULT_FREQ,
    parameter int unsigned UNIT_MS   = DEFAULT_UNIT_MS,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CW        = 4,
    parameter int unsigned GAP_UNITS = DEFAULT_GAP_UNITS
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*CW-1:0] cnt_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [NREQ-1:0]    gnt_o,
    output logic               busy_o,
    output logic               led_o
);

    localparam int unsigned DIV = calc_div(FREQ, UNIT_MS);
    localparam int unsigned LW  = $clog2(NREQ);
    localparam int unsigned UW  = $clog2(GAP_UNITS + 1);

    state_e          state_q, state_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   pcnt_q, pcnt_d;
    logic [UW-1:0]   unit_q, unit_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            tick;
    logic            restart;
    logic            grant;
    logic [LW-1:0]   win;
    logic [CW-1:0]   win_cnt;
    int unsigned     idx;

    blink_scheduler_unit_tick #(.DIV(DIV)) u_phase_tick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // Search starts one past the last winner so every requester gets a turn
    always_comb begin
        grant   = 1'b0;
        win     = last_q;
        win_cnt = '0;
        idx     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_q) + i) % NREQ;
            if (!grant && req_i[idx]) begin
                grant   = 1'b1;
                win     = LW'(idx);
                win_cnt = cnt_i[idx*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= LW'(NREQ - 1);
            pcnt_q <= '0;
            unit_q <= '0;
            ack_q  <= '0;
        end else begin
            last_q <= last_d;
            pcnt_q <= pcnt_d;
            unit_q <= unit_d;
            ack_q  <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        pcnt_d  = pcnt_q;
        ack_d   = '0;
        unit_d  = (state_q == ST_GAP) ? unit_q : '0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    ack_d  = NREQ'(1) << win;
                    last_d = win;
                    pcnt_d = win_cnt;
                    if (win_cnt != '0) begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (tick) begin
                    pcnt_d  = pcnt_q - CW'(1);
                    state_d = (pcnt_d != '0) ? ST_OFF : ST_GAP;
                end
            end
            ST_OFF: begin
                if (tick) begin
                    state_d = ST_ON;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (unit_q == UW'(GAP_UNITS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase timer is held in IDLE and cleared on every state change
    assign restart = (state_q == ST_IDLE) || (state_d != state_q);
    assign ack_o   = ack_q;

`ifdef BLINK_SCHED_HEARTBEAT_EN
    localparam int unsigned HW = $clog2(HB_RATIO);

    logic          hb_tick;
    logic [HW-1:0] hb_q, hb_d;
    logic          hb_on_q;

    blink_scheduler_unit_tick #(.DIV(DIV)) u_hb_tick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .restart_i (1'b0),
        .tick_o    (hb_tick)
    );

    always_comb begin
        hb_d = hb_q;
        if (hb_tick) begin
            hb_d = (hb_q == HW'(HB_RATIO - 1)) ? '0 : hb_q + HW'(1);
        end
    end

    // Registered so the LED stays dark while reset is held
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hb_q    <= '0;
            hb_on_q <= 1'b0;
        end else begin
            hb_q    <= hb_d;
            hb_on_q <= (hb_d == '0);
        end
    end
`endif

    always_comb begin
        busy_o = (state_q != ST_IDLE);
        gnt_o  = busy_o ? (NREQ'(1) << last_q) : '0;
        led_o  = (state_q == ST_ON);
`ifdef BLINK_SCHED_HEARTBEAT_EN
        if (state_q == ST_IDLE) begin
            led_o = hb_on_q;
        end
`endif
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler with a timeline-based reference model
// (grant time, elapsed cycles, code length) compared on every falling edge.
module tb_blink_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int DIV  = 10;
    localparam int GAP  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] cnt;
    logic [NREQ-1:0]    ack_o, gnt_o;
    logic               busy_o, led_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    blink_scheduler #(
        .FREQ      (1000),
        .UNIT_MS   (10),
        .NREQ      (NREQ),
        .CW        (CW),
        .GAP_UNITS (GAP)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .cnt_i  (cnt),
        .ack_o  (ack_o),
        .gnt_o  (gnt_o),
        .busy_o (busy_o),
        .led_o  (led_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a code is a window of (2N-1+GAP)*DIV cycles from its grant
    int              m_owner = -1;
    int              m_el    = 0;
    int              m_n     = 0;
    int              m_last  = NREQ - 1;
    int              m_hb    = 0;
    logic [NREQ-1:0] m_ack   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_el    = 0;
            m_n     = 0;
            m_last  = NREQ - 1;
            m_hb    = 0;
            m_ack   = '0;
        end else begin
            int w;
            m_hb++;
            m_ack = '0;
            if (m_owner >= 0) begin
                m_el++;
                if (m_el >= (2 * m_n - 1 + GAP) * DIV) m_owner = -1;
            end else if (req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (m_last + k) % NREQ;
                    if (w < 0 && req[i]) w = i;
                end
                m_ack[w] = 1'b1;
                m_last   = w;
                m_n      = int'(cnt[w*CW +: CW]);
                if (m_n != 0) begin
                    m_owner = w;
                    m_el    = 0;
                end
            end
        end
    end

    function automatic int exp_led();
        if (m_owner >= 0)
            return (m_el < (2 * m_n - 1) * DIV && (m_el / DIV) % 2 == 0) ? 1 : 0;
`ifdef BLINK_SCHED_HEARTBEAT_EN
        return (m_hb >= 1 && (m_hb / DIV) % 10 == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        check("ack",  int'(ack_o),  int'(m_ack));
        check("gnt",  int'(gnt_o),  (m_owner >= 0) ? (1 << m_owner) : 0);
        check("busy", int'(busy_o), (m_owner >= 0) ? 1 : 0);
        check("led",  int'(led_o),  exp_led());
    end

    // Observation counters for the hand-computed expectations
    int   obs_led_hi, obs_led_rises, obs_busy, obs_gnt;
    int   cyc = 0;
    logic prev_led = 1'b0;
    int   ack_log[$];
    int   ack_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (led_o) obs_led_hi++;
        if (led_o && !prev_led) obs_led_rises++;
        prev_led = led_o;
        if (busy_o) obs_busy++;
        if (gnt_o != '0) obs_gnt++;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_o[i]) begin
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_obs();
        obs_led_hi    = 0;
        obs_led_rises = 0;
        obs_busy      = 0;
        obs_gnt       = 0;
        ack_log.delete();
        ack_cyc.delete();
    endtask

    task automatic wait_acks(input int n, input int bound);
        int k;
        k = 0;
        while (ack_log.size() < n && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("ack_wait", ack_log.size(), n);
    endtask

    initial begin
        rst_n = 1'b1;
        req   = '0;
        cnt   = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        check("rst_led",  int'(led_o),  0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_gnt",  int'(gnt_o),  0);
        check("rst_ack",  int'(ack_o),  0);

        // Idle after reset: everything dark for 200 cycles
        clear_obs();
        repeat (200) @(negedge clk);
        #1;
        check("idle_led_hi", obs_led_hi, 0);
        check("idle_busy",   obs_busy, 0);
        check("idle_gnt",    obs_gnt, 0);
        check("idle_acks",   ack_log.size(), 0);

        // Single requester, two pulses
        @(posedge clk); #2;
        clear_obs();
        req = 4'b0001;
        cnt = 16'h0002;
        wait_acks(1, 20);
        req = '0;
        repeat (80) @(negedge clk);
        #1;
        check("c2_acks",     ack_log.size(), 1);
        check("c2_led_hi",   obs_led_hi, 20);
        check("c2_led_rise", obs_led_rises, 2);
        check("c2_busy",     obs_busy, 60);
        check("c2_gnt_end",  int'(gnt_o), 0);

        // Two requesters held: round-robin 1,3,1,3 spaced 41 cycles apart
        @(posedge clk); #2;
        clear_obs();
        req = 4'b1010;
        cnt = 16'h1111;
        wait_acks(4, 300);
        req = '0;
        if (ack_log.size() == 4) begin
            check("rr_0", ack_log[0], 1);
            check("rr_1", ack_log[1], 3);
            check("rr_2", ack_log[2], 1);
            check("rr_3", ack_log[3], 3);
            for (int i = 1; i < 4; i++)
                check("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 41);
        end
        repeat (50) @(negedge clk);

        // Zero-length code: ack only, then another requester granted next cycle
        @(posedge clk); #2;
        clear_obs();
        req = 4'b0001;
        cnt = 16'h0000;
        wait_acks(1, 20);
        check("z_busy", obs_busy, 0);
        check("z_led",  obs_led_hi, 0);
        req = 4'b0100;
        cnt = 16'h0100;
        wait_acks(2, 20);
        req = '0;
        if (ack_log.size() == 2) begin
            check("z_first",  ack_log[0], 0);
            check("z_second", ack_log[1], 2);
            check("z_gap",    ack_cyc[1] - ack_cyc[0], 1);
        end
        repeat (50) @(negedge clk);

        // Reset in the middle of the second pulse, then a fresh code from pulse 1
        @(posedge clk); #2;
        clear_obs();
        req = 4'b0001;
        cnt = 16'h0003;
        wait_acks(1, 20);
        repeat (25) @(negedge clk);
        #1;
        check("pre_rst_led", int'(led_o), 1);
        rst_n = 1'b0;
        #1;
        check("async_led", int'(led_o), 0);
        check("async_gnt", int'(gnt_o), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        clear_obs();
        wait_acks(1, 20);
        req = '0;
        repeat (100) @(negedge clk);
        #1;
        check("rr_after_rst", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
        check("fresh_rises",  obs_led_rises, 3);
        check("fresh_led_hi", obs_led_hi, 30);
        check("fresh_busy",   obs_busy, 80);

`ifdef BLINK_SCHED_HEARTBEAT_EN
        rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        clear_obs();
        repeat (300) @(negedge clk);
        #1;
        check("hb_led_hi", obs_led_hi, 29);
        req = 4'b0001;
        cnt = 16'h0001;
        wait_acks(1, 20);
        req = '0;
        repeat (150) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
